// File: rtl/channel_arbiter_fifo_if.sv
// rtl/channel_arbiter_fifo_if.sv - valid/ready channel carrying a {pc, cc_id} payload
interface channel_arbiter_fifo_if #(
  parameter int DATA_WIDTH = 9
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/channel_arbiter_fifo.sv
// rtl/channel_arbiter_fifo.sv - round-robin merge of loopback and new-thread channels into a FWFT FIFO
module channel_arbiter_fifo #(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 1,
  parameter int FIFO_COUNT_WIDTH    = 6,
  parameter int LATENCY_COUNT_WIDTH = 8,
  localparam int DATA_WIDTH         = PC_WIDTH + CC_ID_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  channel_arbiter_fifo_if.slave          a,
  channel_arbiter_fifo_if.slave          b,
  channel_arbiter_fifo_if.master         out,
  output logic [LATENCY_COUNT_WIDTH-1:0] out_latency,
  output logic [FIFO_COUNT_WIDTH:0]      count,
  output logic                           empty,
  output logic                           full
);

  localparam int DEPTH = 2 ** FIFO_COUNT_WIDTH;
  localparam int CW    = FIFO_COUNT_WIDTH + 1;
  localparam int XW    = (CW > LATENCY_COUNT_WIDTH) ? CW : LATENCY_COUNT_WIDTH;
  localparam logic [XW-1:0] LAT_MAX = XW'({LATENCY_COUNT_WIDTH{1'b1}});

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [FIFO_COUNT_WIDTH-1:0] rd_ptr;
  logic [FIFO_COUNT_WIDTH-1:0] wr_ptr;
  logic                        last_grant_b;
  logic                        grant_a;
  logic                        grant_b;
  logic                        push_a;
  logic                        push_b;
  logic                        push;
  logic                        pop;
  logic [DATA_WIDTH-1:0]       push_data;
  logic [XW-1:0]               count_x;

  // On a tie the channel that did not win the last accepted push goes first.
  assign grant_a = a.valid & (~b.valid | last_grant_b);
  assign grant_b = b.valid & (~a.valid | ~last_grant_b);

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Readiness is gated by rst so both channels are held off during reset.
  assign a.ready = ~rst & ~full & grant_a;
  assign b.ready = ~rst & ~full & grant_b;

  assign push_a    = a.valid & a.ready;
  assign push_b    = b.valid & b.ready;
  assign push      = push_a | push_b;
  assign push_data = push_a ? a.data : b.data;

  assign out.valid = ~empty;
  assign out.data  = mem[rd_ptr];
  assign pop       = out.valid & out.ready;

  assign count_x     = XW'(count);
  assign out_latency = (count_x > LAT_MAX) ? '1 : count_x[LATENCY_COUNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_grant_b <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        last_grant_b <= push_b;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  assert property (@(posedge clk) !(a.ready && b.ready));

endmodule

// File: tb/tb_channel_arbiter_fifo.sv
// tb/tb_channel_arbiter_fifo.sv - directed checks of arbitration, FIFO ordering, full/empty and latency saturation
module tb_channel_arbiter_fifo;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] lat0;
  logic [6:0] cnt0;
  logic       empty0, full0;
  logic [7:0] lat1;
  logic [2:0] cnt1;
  logic       empty1, full1;
  logic [1:0] lat2;
  logic [3:0] cnt2;
  logic       empty2, full2;

  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) a0 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) b0 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) o0 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) a1 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) b1 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) o1 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) a2 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) b2 ();
  channel_arbiter_fifo_if #(.DATA_WIDTH(9)) o2 ();

  channel_arbiter_fifo u0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .out(o0),
    .out_latency(lat0), .count(cnt0), .empty(empty0), .full(full0)
  );

  channel_arbiter_fifo #(.FIFO_COUNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .out(o1),
    .out_latency(lat1), .count(cnt1), .empty(empty1), .full(full1)
  );

  channel_arbiter_fifo #(.FIFO_COUNT_WIDTH(3), .LATENCY_COUNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .out(o2),
    .out_latency(lat2), .count(cnt2), .empty(empty2), .full(full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  logic [8:0] rr_exp [4];
  logic [8:0] q [$];
  logic [8:0] next_val;
  logic       exp_ready;
  int         na;
  int         nb;

  initial begin
    rst = 1'b1;
    a0.valid = 1'b1; a0.data = 9'h0A5; b0.valid = 1'b0; b0.data = '0; o0.ready = 1'b0;
    a1.valid = 1'b0; a1.data = '0;     b1.valid = 1'b0; b1.data = '0; o1.ready = 1'b0;
    a2.valid = 1'b0; a2.data = '0;     b2.valid = 1'b0; b2.data = '0; o2.ready = 1'b0;

    // reset state, with A already presenting a word
    #2;
    check("rst_out_valid", o0.valid, 0);
    check("rst_a_ready", a0.ready, 0);
    check("rst_b_ready", b0.ready, 0);
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_latency", lat0, 0);
    step;
    rst = 1'b0;
    #1;
    check("single_a_ready", a0.ready, 1);
    step;
    a0.valid = 1'b0;
    #1;
    check("single_out_valid", o0.valid, 1);
    check("single_out_data", o0.data, 9'h0A5);
    check("single_count", cnt0, 1);
    check("single_latency", lat0, 1);

    // round robin, both channels valid every cycle
    pulse_reset;
    step;
    rr_exp[0] = 9'h011; rr_exp[1] = 9'h021; rr_exp[2] = 9'h012; rr_exp[3] = 9'h022;
    na = 0; nb = 0;
    o0.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a0.valid = 1'b1; a0.data = 9'(9'h011 + na);
      b0.valid = 1'b1; b0.data = 9'(9'h021 + nb);
      #1;
      check("rr_a_ready", a0.ready, (k % 2) == 0);
      check("rr_b_ready", b0.ready, (k % 2) == 1);
      if (k >= 1) begin
        check("rr_out_valid", o0.valid, 1);
        check("rr_out_data", o0.data, rr_exp[k-1]);
      end
      step;
      if ((k % 2) == 0) na++; else nb++;
    end
    a0.valid = 1'b0; b0.valid = 1'b0;
    o0.ready = 1'b0;

    // fill depth-4 FIFO from B
    for (int i = 0; i < 4; i++) begin
      b1.valid = 1'b1; b1.data = 9'(9'h031 + i);
      #1;
      check("fill_b_ready", b1.ready, 1);
      step;
    end
    b1.data = 9'h035;
    #1;
    check("fill_full", full1, 1);
    check("fill_count", cnt1, 4);
    check("fill_b_ready_full", b1.ready, 0);
    o1.ready = 1'b1;
    step;
    o1.ready = 1'b0;
    #1;
    check("fill_count_after_pop", cnt1, 3);
    check("fill_full_after_pop", full1, 0);
    check("fill_b_ready_after_pop", b1.ready, 1);
    check("fill_head_after_pop", o1.data, 9'h032);
    step;
    b1.valid = 1'b0;
    o1.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("fill_drain_data", o1.data, 9'(9'h032 + j));
      step;
    end
    #1;
    check("fill_drained_empty", empty1, 1);
    o1.ready = 1'b0;

    // simultaneous push/pop at count=2, then random ready against a scoreboard
    q.delete();
    next_val = 9'h040;
    for (int i = 0; i < 2; i++) begin
      a1.valid = 1'b1; a1.data = next_val;
      step;
      q.push_back(next_val);
      next_val = next_val + 9'd1;
    end
    check("pp_count_start", cnt1, 2);
    o1.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a1.data = next_val;
      #1;
      check("pp_count_steady", cnt1, 2);
      check("pp_head", o1.data, q[0]);
      step;
      void'(q.pop_front());
      q.push_back(next_val);
      next_val = next_val + 9'd1;
    end
    exp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_ready || !a1.valid) begin
        a1.valid = 1'($urandom_range(0, 1));
        a1.data  = next_val;
      end
      o1.ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = a1.valid && (q.size() < 4);
      check("sb_a_ready", a1.ready, exp_ready);
      check("sb_count", cnt1, q.size());
      check("sb_out_valid", o1.valid, q.size() > 0);
      if (q.size() > 0) check("sb_out_data", o1.data, q[0]);
      step;
      if (o1.ready && q.size() > 0) void'(q.pop_front());
      if (exp_ready) begin
        q.push_back(next_val);
        next_val = next_val + 9'd1;
      end
    end
    a1.valid = 1'b0; o1.ready = 1'b0;

    // latency saturation on the 2-bit field
    for (int i = 0; i < 6; i++) begin
      a2.valid = 1'b1; a2.data = 9'(9'h050 + i);
      step;
      check("sat_count", cnt2, i + 1);
      check("sat_latency", lat2, (i + 1 > 3) ? 3 : i + 1);
    end
    a2.valid = 1'b0;

    // asynchronous reset with words queued
    pulse_reset;
    step;
    for (int i = 0; i < 3; i++) begin
      a0.valid = 1'b1; a0.data = 9'(9'h001 + i);
      step;
    end
    a0.valid = 1'b0;
    check("mid_count_before", cnt0, 3);
    #1 rst = 1'b1;
    #1;
    check("mid_out_valid", o0.valid, 0);
    check("mid_count", cnt0, 0);
    check("mid_empty", empty0, 1);
    #1 rst = 1'b0;
    step;
    a0.valid = 1'b1; a0.data = 9'h033;
    step;
    a0.valid = 1'b0;
    #1;
    check("mid_after_valid", o0.valid, 1);
    check("mid_after_data", o0.data, 9'h033);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
